// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand forwarding / scoreboard slice.
package fwd_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;
    localparam int RAW_DEF    = 5;
    localparam int NSRC_DEF   = 2;
    localparam int NSTAGE_DEF = 3;
    localparam int LAT_W_DEF  = 3;

    // Architectural register 0 always reads as zero and is never tracked.
    localparam int ZERO_REG = 0;

    // Upper bound on select width returned by rf_onehot (NSTAGE+1 must fit).
    localparam int MAX_SEL = 16;

    // One-hot select with only the register-file bit (index nstage) set.
    function automatic logic [MAX_SEL-1:0] rf_onehot(input int nstage);
        return {{(MAX_SEL-1){1'b0}}, 1'b1} << nstage;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Bundle of the ID-stage read ports, bypass network, issue/writeback
// sideband and forwarding results seen by fwd_scoreboard.
//
// Handshake: the ID instruction presents issue_valid; it advances on a cycle
// where issue_valid=1 and stall=0 (stall acts as the inverted ready). While
// stall=1 the ID stage holds every input stable and the scoreboard ignores
// the issue. stall never depends on issue_valid, so there is no
// combinational loop through the handshake.
interface fwd_scoreboard_if
    import fwd_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int RAW    = RAW_DEF,
    parameter int NSRC   = NSRC_DEF,
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int LAT_W  = LAT_W_DEF
);

    logic [NSRC*RAW-1:0]         src_addr;
    logic [NSRC-1:0]             src_use;
    logic [NSRC*XLEN-1:0]        src_rdata;
    logic [NSTAGE-1:0]           byp_valid;
    logic [NSTAGE*RAW-1:0]       byp_rd;
    logic [NSTAGE*XLEN-1:0]      byp_data;
    logic                        issue_valid;
    logic                        issue_wen;
    logic [RAW-1:0]              issue_rd;
    logic [LAT_W-1:0]            issue_lat;
    logic                        wb_valid;
    logic [RAW-1:0]              wb_rd;
    logic                        flush;
    logic [NSRC*XLEN-1:0]        fwd_data;
    logic [NSRC*(NSTAGE+1)-1:0]  fwd_sel;
    logic                        stall;
    logic [NREG-1:0]             busy_vec;

    // Pipeline side: drives operands, bypass and issue info, consumes results.
    modport master (
        output src_addr, src_use, src_rdata, byp_valid, byp_rd, byp_data,
        output issue_valid, issue_wen, issue_rd, issue_lat, wb_valid, wb_rd, flush,
        input  fwd_data, fwd_sel, stall, busy_vec
    );

    // Forwarding unit side.
    modport slave (
        input  src_addr, src_use, src_rdata, byp_valid, byp_rd, byp_data,
        input  issue_valid, issue_wen, issue_rd, issue_lat, wb_valid, wb_rd, flush,
        output fwd_data, fwd_sel, stall, busy_vec
    );

endinterface

// File: rtl/fwd_mux.sv
// One operand's bypass selection: youngest matching stage wins, otherwise
// the register file; register 0 always comes from the register file.
module fwd_mux
    import fwd_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RAW    = RAW_DEF,
    parameter int NSTAGE = NSTAGE_DEF
) (
    input  logic [RAW-1:0]         src_addr,
    input  logic [XLEN-1:0]        src_rdata,
    input  logic [NSTAGE-1:0]      byp_valid,
    input  logic [NSTAGE*RAW-1:0]  byp_rd,
    input  logic [NSTAGE*XLEN-1:0] byp_data,
    output logic [NSTAGE:0]        sel,
    output logic [XLEN-1:0]        data
);

    // Priority compare: scan from the youngest stage, first hit claims the select.
    always_comb begin
        logic hit;
        hit = 1'b0;
        sel = (NSTAGE+1)'(rf_onehot(NSTAGE));
        if (src_addr != RAW'(ZERO_REG)) begin
            for (int s = 0; s < NSTAGE; s++) begin
                if (!hit && byp_valid[s] && (byp_rd[s*RAW +: RAW] == src_addr)) begin
                    hit = 1'b1;
                    sel = (NSTAGE+1)'(1) << s;
                end
            end
        end
    end

    // AND-OR select; sel is one-hot so at most one term is non-zero.
    always_comb begin
        data = src_rdata & {XLEN{sel[NSTAGE]}};
        for (int s = 0; s < NSTAGE; s++) begin
            data |= byp_data[s*XLEN +: XLEN] & {XLEN{sel[s]}};
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// ID-stage operand forwarding plus a per-register latency scoreboard that
// turns not-yet-available multi-cycle results into stalls.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int RAW    = RAW_DEF,
    parameter int NSRC   = NSRC_DEF,
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int LAT_W  = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_scoreboard_if.slave  bus
);

    logic [NREG-1:0]  busy;
    logic [LAT_W-1:0] cnt [NREG];
    logic             stall_c;
    logic             fire;

    logic [NSRC*XLEN-1:0]       fwd_data_w;
    logic [NSRC*(NSTAGE+1)-1:0] fwd_sel_w;

    // Hazard: a used, non-zero source whose producer has not reached a bypass stage yet.
    always_comb begin
        logic [RAW-1:0] a;
        stall_c = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            a = bus.src_addr[i*RAW +: RAW];
            if (bus.src_use[i] && (a != RAW'(ZERO_REG)) && busy[a] && (cnt[a] != '0)) begin
                stall_c = 1'b1;
            end
        end
    end

    // An issue only claims a register when it actually leaves ID and no flush squashes it.
    always_comb begin
        fire = bus.issue_valid && !stall_c && bus.issue_wen &&
               (bus.issue_rd != RAW'(ZERO_REG)) && !bus.flush;
    end

    // Scoreboard update: issue (wins over retire) or retire, with latency countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else if (bus.flush) begin
            busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            busy[0] <= 1'b0;
            cnt[0]  <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (fire && (bus.issue_rd == RAW'(r))) begin
                    busy[r] <= 1'b1;
                    cnt[r]  <= bus.issue_lat;
                end else begin
                    if (bus.wb_valid && (bus.wb_rd == RAW'(r))) begin
                        busy[r] <= 1'b0;
                    end
                    if (busy[r] && (cnt[r] != '0)) begin
                        cnt[r] <= cnt[r] - LAT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_mux #(
            .XLEN   (XLEN),
            .RAW    (RAW),
            .NSTAGE (NSTAGE)
        ) u_mux (
            .src_addr  (bus.src_addr[i*RAW +: RAW]),
            .src_rdata (bus.src_rdata[i*XLEN +: XLEN]),
            .byp_valid (bus.byp_valid),
            .byp_rd    (bus.byp_rd),
            .byp_data  (bus.byp_data),
            .sel       (fwd_sel_w[i*(NSTAGE+1) +: (NSTAGE+1)]),
            .data      (fwd_data_w[i*XLEN +: XLEN])
        );
    end

    assign bus.fwd_data = fwd_data_w;
    assign bus.fwd_sel  = fwd_sel_w;
    assign bus.stall    = stall_c;
    assign bus.busy_vec = busy;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a cycle-time model (ready cycle per
// register) checked every cycle, plus hand-computed literal expectations.
module tb_fwd_scoreboard;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int RAW    = 5;
    localparam int NSRC   = 2;
    localparam int NSTAGE = 3;
    localparam int LAT_W  = 3;
    localparam int SELW   = NSTAGE + 1;

    logic clk = 1'b0;
    logic rst_n;

    fwd_scoreboard_if #(
        .XLEN(XLEN), .NREG(NREG), .RAW(RAW), .NSRC(NSRC), .NSTAGE(NSTAGE), .LAT_W(LAT_W)
    ) bus ();

    fwd_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .RAW(RAW), .NSRC(NSRC), .NSTAGE(NSTAGE), .LAT_W(LAT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A register is pending while busy and the current cycle is before the
    // cycle its result reaches a bypass stage.
    bit     m_busy  [NREG];
    longint m_ready [NREG];
    longint cyc = 0;

    function automatic bit model_stall();
        for (int i = 0; i < NSRC; i++) begin
            int a;
            a = int'(bus.src_addr[i*RAW +: RAW]);
            if (bus.src_use[i] && a != 0 && m_busy[a] && cyc < m_ready[a]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NSTAGE:0] model_sel(input int i);
        logic [NSTAGE:0] r;
        int a;
        a = int'(bus.src_addr[i*RAW +: RAW]);
        r = '0;
        r[NSTAGE] = 1'b1;
        if (a == 0) return r;
        for (int s = 0; s < NSTAGE; s++) begin
            if (bus.byp_valid[s] && int'(bus.byp_rd[s*RAW +: RAW]) == a) begin
                r = '0;
                r[s] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] model_data(input int i);
        int a;
        a = int'(bus.src_addr[i*RAW +: RAW]);
        if (a != 0) begin
            for (int s = 0; s < NSTAGE; s++) begin
                if (bus.byp_valid[s] && int'(bus.byp_rd[s*RAW +: RAW]) == a)
                    return bus.byp_data[s*XLEN +: XLEN];
            end
        end
        return bus.src_rdata[i*XLEN +: XLEN];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                m_busy[r]  <= 1'b0;
                m_ready[r] <= 0;
            end
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (bus.flush) begin
                for (int r = 0; r < NREG; r++) begin
                    m_busy[r]  <= 1'b0;
                    m_ready[r] <= 0;
                end
            end else begin
                if (bus.wb_valid && bus.wb_rd != 0) m_busy[bus.wb_rd] <= 1'b0;
                if (bus.issue_valid && bus.issue_wen && bus.issue_rd != 0 && !model_stall()) begin
                    m_busy[bus.issue_rd]  <= 1'b1;
                    m_ready[bus.issue_rd] <= cyc + 1 + longint'(bus.issue_lat);
                end
            end
        end
    end

    // Compare process: every cycle, on the inactive edge.
    always @(negedge clk) begin
        logic [NREG-1:0] eb;
        for (int r = 0; r < NREG; r++) eb[r] = m_busy[r];
        check("model_stall", 64'(bus.stall), 64'(model_stall()));
        check("model_busy_vec", 64'(bus.busy_vec), 64'(eb));
        for (int i = 0; i < NSRC; i++) begin
            check("model_fwd_sel", 64'(bus.fwd_sel[i*SELW +: SELW]), 64'(model_sel(i)));
            check("model_fwd_data", 64'(bus.fwd_data[i*XLEN +: XLEN]), 64'(model_data(i)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.src_addr    = '0;
        bus.src_use     = '0;
        bus.src_rdata   = {32'hCAFE_0001, 32'hCAFE_0000};
        bus.byp_valid   = '0;
        bus.byp_rd      = '0;
        bus.byp_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_wen   = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_lat   = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rd, input int lat);
        bus.issue_valid = 1'b1;
        bus.issue_wen   = 1'b1;
        bus.issue_rd    = RAW'(rd);
        bus.issue_lat   = LAT_W'(lat);
    endtask

    task automatic set_src(input int i, input int addr, input bit use_it, input logic [XLEN-1:0] d);
        bus.src_addr[i*RAW +: RAW]    = RAW'(addr);
        bus.src_use[i]                = use_it;
        bus.src_rdata[i*XLEN +: XLEN] = d;
    endtask

    task automatic set_byp(input int s, input bit v, input int rd, input logic [XLEN-1:0] d);
        bus.byp_valid[s]             = v;
        bus.byp_rd[s*RAW +: RAW]     = RAW'(rd);
        bus.byp_data[s*XLEN +: XLEN] = d;
    endtask

    // Count consecutive stalled cycles from now, bounded.
    task automatic count_stall(output int n);
        n = 0;
        for (int k = 0; k < 20 && bus.stall; k++) begin
            n++;
            step();
            #2;
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [2:0] tv_valid [4] = '{3'b111, 3'b111, 3'b101, 3'b111};
    int         tv_rd0   [4] = '{4, 6, 6, 6};
    int         tv_rd1   [4] = '{4, 4, 4, 6};
    int         tv_rd2   [4] = '{4, 4, 4, 6};
    logic [XLEN-1:0] tv_exp [4] = '{32'hA, 32'hB, 32'hC, 32'h4444};
    logic [3:0]      tv_sel [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        int n;
        logic [XLEN-1:0] e;
        rst_n = 1'b0;
        idle();
        repeat (2) step();
        #2;
        check("reset_busy_vec", 64'(bus.busy_vec), 64'h0);
        check("reset_stall", 64'(bus.stall), 64'h0);
        check("reset_fwd_sel", 64'(bus.fwd_sel), 64'h88);
        check("reset_fwd_data", 64'(bus.fwd_data), 64'hCAFE_0001_CAFE_0000);
        rst_n = 1'b1;
        step();

        // Reset in the middle of operation.
        issue(5, 2);
        step();
        bus.issue_valid = 1'b0;
        set_src(0, 5, 1'b1, 32'h5555_0005);
        #2;
        check("midop_busy5", 64'(bus.busy_vec), 64'h20);
        check("midop_stall", 64'(bus.stall), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy_vec", 64'(bus.busy_vec), 64'h0);
        check("async_rst_stall", 64'(bus.stall), 64'h0);
        check("async_rst_fwd_data0", 64'(bus.fwd_data[31:0]), 64'h5555_0005);
        check("async_rst_fwd_sel0", 64'(bus.fwd_sel[3:0]), 64'h8);
        step();
        rst_n = 1'b1;
        idle();
        step();

        // ALU chain: lat 0, back-to-back forwarding from stage 0.
        issue(3, 0);
        step();
        bus.issue_valid = 1'b0;
        set_src(0, 3, 1'b1, 32'h0);
        set_byp(0, 1'b1, 3, 32'h1234);
        #2;
        check("alu_stall", 64'(bus.stall), 64'h0);
        check("alu_fwd_data0", 64'(bus.fwd_data[31:0]), 64'h1234);
        check("alu_fwd_sel0", 64'(bus.fwd_sel[3:0]), 64'h1);
        step();
        idle();

        // Load-use: lat 1 gives exactly one stall cycle.
        issue(7, 1);
        step();
        bus.issue_valid = 1'b1;
        bus.issue_wen   = 1'b0;
        bus.issue_rd    = '0;
        set_src(1, 7, 1'b1, 32'h0);
        #2;
        check("load_use_stall_1", 64'(bus.stall), 64'h1);
        step();
        set_byp(0, 1'b1, 7, 32'hDEAD_BEEF);
        #2;
        check("load_use_stall_0", 64'(bus.stall), 64'h0);
        check("load_use_fwd_data1", 64'(bus.fwd_data[63:32]), 64'hDEAD_BEEF);
        check("load_use_fwd_sel1", 64'(bus.fwd_sel[7:4]), 64'h1);
        step();
        idle();

        // Priority among stages.
        set_src(0, 4, 1'b1, 32'h4444);
        for (int v = 0; v < 4; v++) begin
            set_byp(0, tv_valid[v][0], tv_rd0[v], 32'hA);
            set_byp(1, tv_valid[v][1], tv_rd1[v], 32'hB);
            set_byp(2, tv_valid[v][2], tv_rd2[v], 32'hC);
            exp_q.push_back(tv_exp[v]);
            #2;
            e = exp_q.pop_front();
            check("prio_fwd_data0", 64'(bus.fwd_data[31:0]), 64'(e));
            check("prio_fwd_sel0", 64'(bus.fwd_sel[3:0]), 64'(tv_sel[v]));
            step();
        end
        set_src(0, 0, 1'b1, 32'h0);
        set_byp(0, 1'b1, 0, 32'hA);
        set_byp(1, 1'b1, 0, 32'hB);
        set_byp(2, 1'b1, 0, 32'hC);
        #2;
        check("x0_fwd_data0", 64'(bus.fwd_data[31:0]), 64'h0);
        check("x0_fwd_sel0", 64'(bus.fwd_sel[3:0]), 64'h8);
        step();
        idle();

        // Divide lat 5: unused operand never stalls, used operand stalls 5 cycles.
        issue(9, 5);
        step();
        bus.issue_valid = 1'b0;
        set_src(0, 9, 1'b0, 32'h0);
        #2;
        check("div_unused_stall", 64'(bus.stall), 64'h0);
        bus.src_use[0] = 1'b1;
        #1;
        count_stall(n);
        check("div_stall_cycles", 64'(n), 64'd5);
        // Same-cycle retire and reissue of rd 9: issue wins, cnt reloads to 2.
        bus.src_use[0] = 1'b0;
        bus.wb_valid   = 1'b1;
        bus.wb_rd      = RAW'(9);
        issue(9, 2);
        step();
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        #2;
        check("reissue_busy9", 64'(bus.busy_vec[9]), 64'h1);
        bus.src_use[0] = 1'b1;
        #1;
        count_stall(n);
        check("reissue_stall_cycles", 64'(n), 64'd2);
        idle();
        step();

        // Flush squashes the scoreboard and a simultaneous issue.
        issue(2, 0);
        step();
        issue(8, 0);
        step();
        bus.issue_valid = 1'b0;
        #2;
        check("pre_flush_busy_2_8", 64'({bus.busy_vec[8], bus.busy_vec[2]}), 64'h3);
        bus.flush = 1'b1;
        issue(11, 0);
        step();
        bus.flush = 1'b0;
        bus.issue_valid = 1'b0;
        #2;
        check("flush_busy_vec", 64'(bus.busy_vec), 64'h0);
        issue(11, 0);
        step();
        bus.issue_valid = 1'b0;
        #2;
        check("post_flush_issue", 64'(bus.busy_vec), 64'h800);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = RAW'(11);
        step();
        bus.wb_valid = 1'b0;
        #2;
        check("retire_busy_vec", 64'(bus.busy_vec), 64'h0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand forwarding and hazard unit for the ID stage of the pipeline; generalises the two-stage MEM/WB bypass to NSTAGE bypass stages and NSRC source operands.
- Adds a per-register scoreboard with latency countdown, so multi-cycle producers (loads, mul/div) generate stalls instead of forwarding stale data.
- Sits between the register file read ports and the ID/EX pipeline register; the stall output feeds the hazard controller.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural register count; register 0 is hard-wired zero.
- RAW, 5, register address width (clog2 NREG).
- NSRC, 2, source operands per instruction.
- NSTAGE, 3, bypass stages; index 0 is youngest (EX/MEM), NSTAGE-1 is WB.
- LAT_W, 3, width of the producer latency field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- src_addr  in  NSRC*RAW  source register addresses.
- src_use  in  NSRC  the operand is actually read by the instruction.
- src_rdata  in  NSRC*XLEN  register file read data.
- byp_valid  in  NSTAGE  bypass stage holds a register-writing instruction.
- byp_rd  in  NSTAGE*RAW  destination register per stage.
- byp_data  in  NSTAGE*XLEN  result per stage.
- issue_valid  in  1  ID instruction is valid and wants to advance.
- issue_wen  in  1  ID instruction writes a register.
- issue_rd  in  RAW  ID destination register.
- issue_lat  in  LAT_W  cycles until the result first appears on a bypass stage.
- wb_valid  in  1  writeback retiring this cycle.
- wb_rd  in  RAW  writeback destination.
- flush  in  1  squash the scoreboard.
- fwd_data  out  NSRC*XLEN  forwarded operands.
- fwd_sel  out  NSRC*(NSTAGE+1)  one-hot source per operand; bit NSTAGE selects the register file.
- stall  out  1  hazard; ID must hold.
- busy_vec  out  NREG  scoreboard busy bits (debug/verification).

Behaviour:
- Scoreboard state: busy[r] (1 bit) and cnt[r] (LAT_W bits) per register; r=0 is never busy.
- Reset (rst_n low, asynchronous): all busy=0 and cnt=0. Consequently stall=0, busy_vec=0, fwd_sel selects the register file and fwd_data=src_rdata.
- Issue: fire = issue_valid && !stall && issue_wen && issue_rd!=0. On fire at edge t: busy[issue_rd]=1 and cnt[issue_rd]=issue_lat.
- Countdown: every cycle, each busy entry with cnt!=0 decrements by 1 and saturates at 0.
- Retire: wb_valid && wb_rd!=0 clears busy[wb_rd].
  - If fire targets the same register in the same cycle, issue wins: busy=1 and cnt is reloaded.
- Flush: clears all busy and cnt on the next edge and suppresses a simultaneous issue. The hazard controller guarantees no older instruction with cnt!=0 is outstanding when flush is raised.
- Stall (combinational from registered state): asserted if any operand i has src_use[i] && src_addr[i]!=0 && busy[src_addr[i]] && cnt[src_addr[i]]!=0.
  - Unused operands never stall.
  - Latency contract: issue_lat=0 gives back-to-back forwarding from stage 0; issue_lat=L stalls a dependent instruction issued the next cycle for exactly L cycles.
- Forwarding (combinational), per operand i:
  - If src_addr[i]==0, select the register file.
  - Otherwise pick the lowest stage index s with byp_valid[s] && byp_rd[s]==src_addr[i] (youngest wins).
  - If no stage matches, select the register file.
  - fwd_sel is always exactly one-hot, including during stall.
- Register file: read-before-write, so the WB stage must be present as stage NSTAGE-1.

Decomposition:
- Package fwd_pkg: default XLEN/RAW/NSTAGE constants, a ZERO_REG constant, and a function returning the one-hot register-file select.
- Sub-module fwd_mux: one operand's priority compare and AND-OR select over NSTAGE+1 inputs, instantiated NSRC times.
- Scoreboard and stall logic live in fwd_scoreboard.

Test Plan:
- Reset mid-operation: busy[5] set with cnt=2, then rst_n pulsed low -> busy_vec=0 immediately (asynchronous), stall=0, fwd_data=src_rdata.
- ALU chain: issue rd=3 with lat=0, next cycle src_addr[0]=3 with byp_valid[0]=1, byp_rd[0]=3, byp_data[0]=0x1234 -> stall=0, fwd_data[0]=0x1234, fwd_sel[0]=0001.
- Load-use: issue rd=7 with lat=1, next cycle src_addr[1]=7 -> stall=1 for exactly 1 cycle; then forward from stage 0 with value 0xDEADBEEF.
- Priority: stages 0, 1 and 2 all hold rd=4 with data 0xA, 0xB, 0xC -> fwd_data=0xA. With src_addr=0 and the same stages holding rd=0 -> register-file value 0.
- Divide lat=5 on rd=9 with src_use[0]=0 and src_addr[0]=9 -> no stall. With src_use[0]=1 -> stall for 5 cycles. Same-cycle wb_rd=9 and a new issue rd=9 with lat=2 -> busy[9]=1, cnt=2.
- Flush with busy[2] and busy[8] set, plus a simultaneous issue rd=11 -> busy_vec=0 the next cycle; rd=11 is not marked busy.
